program_sequencer: RTL and testbench
====================================

# program_sequencer

Parametrised program-counter sequencer for the single-cycle MIPS datapath. It holds the instruction address and selects the next PC from sequential, branch, jump, jump-register and return sources. An internal return-address stack (RAS) is pushed on `jal` and popped on `ret`, with overflow and underflow handling. A two-state run/halt machine and a level stall input control when the PC advances.

## Interface
- `ADDR_W`, 32: PC and target width.
- `STEP`, 1: sequential increment (1 = word-addressed memory, 4 = byte-addressed).
- `RAS_DEPTH`, 8: return-stack entries; must be ≥ 2.
- `RESET_ADDR`, 0: PC value after reset.
- `TRAP_ADDR`, 'h40: PC loaded when `ret` hits an empty RAS.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `halt`  in  1  pulse: enter HALTED.
- `resume`  in  1  pulse: leave HALTED.
- `stall`  in  1  level: hold PC and RAS this cycle.
- `branch`  in  1  conditional-branch instruction.
- `branch_ne`  in  1  0 = take when `zero`=1 (beq); 1 = take when `zero`=0 (bne).
- `zero`  in  1  ALU zero flag.
- `branch_target`  in  ADDR_W  absolute branch target.
- `jmp`  in  1  unconditional jump.
- `jal`  in  1  jump-and-link; also pushes the link address onto the RAS.
- `jump_target`  in  ADDR_W  target for `jmp` and `jal`.
- `jr`  in  1  jump to register; does not touch the RAS.
- `jr_target`  in  ADDR_W  register value for `jr`.
- `ret`  in  1  return: pop the RAS and jump to the popped address.
- `pc`  out  ADDR_W  current PC (registered).
- `link_addr`  out  ADDR_W  `pc + STEP` (combinational).
- `halted`  out  1  1 while in HALTED.
- `ras_count`  out  $clog2(RAS_DEPTH+1)  number of valid RAS entries.
- `ras_overflow`  out  1  sticky; set when `jal` pushes onto a full RAS.
- `ras_underflow`  out  1  sticky; set when `ret` pops an empty RAS.

## Operation
- **FSM states.** RUN and HALTED.
  - RUN → HALTED when `halt`=1.
  - HALTED → RUN when `resume`=1 and `halt`=0.
  - In HALTED, PC and RAS hold and all control inputs are ignored.
- **Next-PC priority** (the first true condition wins):
  1. `reset`
  2. `halt`, or state = HALTED
  3. `stall`
  4. `ret`
  5. `jr`
  6. `jal`
  7. `jmp`
  8. branch taken
  9. sequential
- **Branch taken.** `branch & (zero ^ branch_ne)`.
- **Sequential.** `pc <= pc + STEP`, modulo 2^ADDR_W. Wrap from all-ones to 0 is legal and silent.
- **jal.** `pc <= jump_target` and push `link_addr`.
  - If the RAS is full, the oldest entry is overwritten (circular buffer), `ras_count` stays at RAS_DEPTH, and `ras_overflow` is set.
- **ret, RAS not empty.** `pc <=` top entry, and `ras_count` decrements.
- **ret, RAS empty.** `pc <= TRAP_ADDR`, `ras_underflow` is set, and `ras_count` stays 0.
- **Simultaneous requests.** A lower-priority request asserted together with a higher-priority one has no effect at all: `jal` with `ret` does not push, and `ret` with `stall` does not pop.
- **Sticky flags.** `ras_overflow` and `ras_underflow` clear only on reset.

## Timing
- Values after reset: `pc`=RESET_ADDR, state RUN, `halted`=0, `ras_count`=0, both sticky flags 0. RAS entry contents are don't-care.
- Reset asserted mid-operation (HALTED, or during a push/pop) overrides everything on that edge.
- Next-PC decision is combinational from the inputs of the current cycle. `pc`, the RAS and the flags update on the same edge (one-cycle latency).
- `halted` rises on the edge after `halt` is sampled; `pc` does not change on that edge.
- `resume` sampled at edge N: PC advances normally starting at edge N+1.
- `link_addr` follows `pc` combinationally, with no added latency.

## Structure
- Package `program_sequencer_pkg` holds:
  - the state enum (`ST_RUN`, `ST_HALTED`);
  - the next-PC source enum (`SRC_HOLD`, `SRC_RET`, `SRC_JR`, `SRC_JAL`, `SRC_JMP`, `SRC_BR`, `SRC_SEQ`, `SRC_TRAP`).
- Sub-module `ras_stack`, a circular LIFO:
  - parameters: `WIDTH`, `DEPTH`;
  - ports: `push`, `pop`, `din`, `top`, `count`, `full`, `empty`;
  - wraparound overwrite on push when full.
- The top level contains the priority encoder, the FSM and the PC register.

## Test plan
- Reset, then 5 free-running cycles, STEP=1 → `pc` = 0,1,2,3,4,5; `ras_count`=0; no flags.
- `jal` at pc=3 to 0x20, then `ret` at 0x22 → `pc`=0x20, `ras_count`=1; after `ret`, `pc`=4 and `ras_count`=0.
- RAS_DEPTH=2, three nested `jal` (links 0x11, 0x21, 0x31), then three `ret` →
  - the pops return 0x31, then 0x21;
  - the third `ret` gives `pc`=TRAP_ADDR;
  - `ras_overflow`=1 and `ras_underflow`=1.
- `jal` and `ret` together, and `jmp` and branch-taken together →
  - `ret` wins with no push;
  - `jmp` target wins over the branch.
- `halt` at pc=7, then 4 idle cycles, then `resume` →
  - `halted`=1 and `pc` holds 7 throughout;
  - the next edge after `resume` gives `pc`=8;
  - `stall` held 2 cycles freezes `pc` for exactly those 2 edges.
- ADDR_W=8, `pc`=0xFF sequential → `pc`=0x00. Reset asserted while HALTED with `ras_count`=2 → `pc`=RESET_ADDR, RUN, `ras_count`=0.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// Shared types for the program sequencer: run/halt state and next-PC source selector.
package program_sequencer_pkg;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_RET,
        SRC_JR,
        SRC_JAL,
        SRC_JMP,
        SRC_BR,
        SRC_SEQ,
        SRC_TRAP
    } src_t;

endpackage

// File: rtl/program_sequencer_ras_stack.sv
// Circular return-address stack; a push onto a full stack silently overwrites the oldest entry.
module ras_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             top,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] topPtr;

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptrDec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_W'(DEPTH - 1) : p - 1'b1;
    endfunction

    // wrPtr is the next free slot; when full it also points at the oldest entry
    assign topPtr = ptrDec(wrPtr);
    assign top    = mem[topPtr];
    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            count <= '0;
        end else if (push) begin
            wrPtr <= ptrInc(wrPtr);
            if (!full)
                count <= count + 1'b1;
        end else if (pop && !empty) begin
            wrPtr <= topPtr;
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !reset)
            mem[wrPtr] <= din;
    end

endmodule

// File: rtl/program_sequencer.sv
// Program-counter sequencer: prioritised next-PC select, run/halt FSM and return-address stack.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int unsigned       STEP       = 1,
    parameter int                RAS_DEPTH  = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter logic [ADDR_W-1:0] TRAP_ADDR  = 'h40
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             halt,
    input  logic                             resume,
    input  logic                             stall,
    input  logic                             branch,
    input  logic                             branch_ne,
    input  logic                             zero,
    input  logic [ADDR_W-1:0]                branch_target,
    input  logic                             jmp,
    input  logic                             jal,
    input  logic [ADDR_W-1:0]                jump_target,
    input  logic                             jr,
    input  logic [ADDR_W-1:0]                jr_target,
    input  logic                             ret,
    output logic [ADDR_W-1:0]                pc,
    output logic [ADDR_W-1:0]                link_addr,
    output logic                             halted,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_overflow,
    output logic                             ras_underflow
);
    state_t            state;
    src_t              srcSel;
    logic [ADDR_W-1:0] nextPc;
    logic [ADDR_W-1:0] rasTop;
    logic              rasFull;
    logic              rasEmpty;
    logic              rasPush;
    logic              rasPop;
    logic              brTaken;

    assign link_addr = pc + ADDR_W'(STEP);
    assign halted    = (state == ST_HALTED);
    assign brTaken   = branch & (zero ^ branch_ne);

    always_comb begin
        srcSel = SRC_SEQ;
        if (halt || state == ST_HALTED) srcSel = SRC_HOLD;
        else if (stall)                 srcSel = SRC_HOLD;
        else if (ret)                   srcSel = rasEmpty ? SRC_TRAP : SRC_RET;
        else if (jr)                    srcSel = SRC_JR;
        else if (jal)                   srcSel = SRC_JAL;
        else if (jmp)                   srcSel = SRC_JMP;
        else if (brTaken)               srcSel = SRC_BR;
    end

    always_comb begin
        nextPc = link_addr;
        case (srcSel)
            SRC_HOLD: nextPc = pc;
            SRC_RET:  nextPc = rasTop;
            SRC_TRAP: nextPc = TRAP_ADDR;
            SRC_JR:   nextPc = jr_target;
            SRC_JAL:  nextPc = jump_target;
            SRC_JMP:  nextPc = jump_target;
            SRC_BR:   nextPc = branch_target;
            default:  nextPc = link_addr;
        endcase
    end

    // Only the winning source may touch the stack, so masked jal/ret requests are inert
    assign rasPush = (srcSel == SRC_JAL);
    assign rasPop  = (srcSel == SRC_RET);

    ras_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) uRas (
        .clock (clock),
        .reset (reset),
        .push  (rasPush),
        .pop   (rasPop),
        .din   (link_addr),
        .top   (rasTop),
        .count (ras_count),
        .full  (rasFull),
        .empty (rasEmpty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_RUN;
            pc            <= RESET_ADDR;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            case (state)
                ST_RUN:    if (halt) state <= ST_HALTED;
                ST_HALTED: if (resume && !halt) state <= ST_RUN;
                default:   state <= ST_RUN;
            endcase
            pc <= nextPc;
            if (rasPush && rasFull)
                ras_overflow <= 1'b1;
            if (srcSel == SRC_TRAP)
                ras_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer (ADDR_W=8, RAS_DEPTH=2, STEP=1).
module tb_program_sequencer;
    logic       clock = 1'b0;
    logic       reset, halt, resume, stall, branch, branch_ne, zero;
    logic       jmp, jal, jr, ret;
    logic [7:0] branch_target, jump_target, jr_target;
    logic [7:0] pc, link_addr;
    logic       halted, ras_overflow, ras_underflow;
    logic [1:0] ras_count;

    int total = 0;
    int bad   = 0;

    program_sequencer #(
        .ADDR_W     (8),
        .STEP       (1),
        .RAS_DEPTH  (2),
        .RESET_ADDR (8'h00),
        .TRAP_ADDR  (8'h40)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .halt          (halt),
        .resume        (resume),
        .stall         (stall),
        .branch        (branch),
        .branch_ne     (branch_ne),
        .zero          (zero),
        .branch_target (branch_target),
        .jmp           (jmp),
        .jal           (jal),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_target     (jr_target),
        .ret           (ret),
        .pc            (pc),
        .link_addr     (link_addr),
        .halted        (halted),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idleInputs();
        halt = 0; resume = 0; stall = 0; branch = 0; branch_ne = 0; zero = 0;
        jmp = 0; jal = 0; jr = 0; ret = 0;
        branch_target = 8'h00; jump_target = 8'h00; jr_target = 8'h00;
    endtask

    task automatic checkPc(input string tag, input logic [7:0] expPc, input logic [1:0] expCnt);
        check({tag, "_pc"}, {24'd0, pc}, {24'd0, expPc});
        check({tag, "_cnt"}, {30'd0, ras_count}, {30'd0, expCnt});
    endtask

    initial begin
        idleInputs();
        reset = 1;
        step();
        step();
        check("rst_pc", {24'd0, pc}, 32'h00);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_cnt", {30'd0, ras_count}, 32'd0);
        check("rst_ovf", {31'd0, ras_overflow}, 32'd0);
        check("rst_unf", {31'd0, ras_underflow}, 32'd0);
        reset = 0;

        // Free-running sequential fetch
        for (int i = 1; i <= 5; i++) begin
            step();
            checkPc($sformatf("seq%0d", i), 8'(i), 2'd0);
        end
        check("link5", {24'd0, link_addr}, 32'h06);
        check("seq_ovf", {31'd0, ras_overflow}, 32'd0);

        // jal at pc=3, ret at 0x22
        reset = 1; step(); reset = 0;
        step(); step(); step();
        checkPc("at3", 8'h03, 2'd0);
        jal = 1; jump_target = 8'h20; step(); jal = 0;
        checkPc("jal1", 8'h20, 2'd1);
        step(); step();
        checkPc("at22", 8'h22, 2'd1);
        ret = 1; step(); ret = 0;
        checkPc("ret1", 8'h04, 2'd0);

        // Nested calls on a two-entry stack with overflow, then underflow
        jmp = 1; jump_target = 8'h10; step(); jmp = 0;
        checkPc("jmp10", 8'h10, 2'd0);
        jal = 1; jump_target = 8'h20; step();
        checkPc("nest1", 8'h20, 2'd1);
        jump_target = 8'h30; step();
        checkPc("nest2", 8'h30, 2'd2);
        check("nest2_ovf", {31'd0, ras_overflow}, 32'd0);
        jump_target = 8'h50; step(); jal = 0;
        checkPc("nest3", 8'h50, 2'd2);
        check("nest3_ovf", {31'd0, ras_overflow}, 32'd1);
        ret = 1; step();
        checkPc("pop1", 8'h31, 2'd1);
        step();
        checkPc("pop2", 8'h21, 2'd0);
        check("pop2_unf", {31'd0, ras_underflow}, 32'd0);
        step(); ret = 0;
        checkPc("pop3", 8'h40, 2'd0);
        check("pop3_unf", {31'd0, ras_underflow}, 32'd1);
        check("pop3_ovf", {31'd0, ras_overflow}, 32'd1);

        // Simultaneous requests: ret beats jal, jmp beats branch
        jal = 1; jump_target = 8'h60; step(); jal = 0;
        checkPc("jal60", 8'h60, 2'd1);
        jal = 1; ret = 1; jump_target = 8'h70; step(); jal = 0; ret = 0;
        checkPc("jal_ret", 8'h41, 2'd0);
        jmp = 1; jump_target = 8'h80; branch = 1; zero = 1; branch_ne = 0; branch_target = 8'h90;
        step(); jmp = 0;
        checkPc("jmp_br", 8'h80, 2'd0);
        step();
        checkPc("beq_tk", 8'h90, 2'd0);
        branch_ne = 1; step();
        checkPc("bne_nt", 8'h91, 2'd0);
        zero = 0; branch_target = 8'h05; step(); branch = 0; branch_ne = 0;
        checkPc("bne_tk", 8'h05, 2'd0);
        zero = 1; branch_target = 8'h00; branch = 1; step(); branch = 0; zero = 0;
        checkPc("beq_nt_after", 8'h00, 2'd0);

        // Get back to a known frame: jmp to 5, call to 7 (link 6)
        jmp = 1; jump_target = 8'h05; step(); jmp = 0;
        jal = 1; jump_target = 8'h07; step(); jal = 0;
        checkPc("call7", 8'h07, 2'd1);
        stall = 1; ret = 1; step(); stall = 0; ret = 0;
        checkPc("stall_ret", 8'h07, 2'd1);

        // Halt at pc=7, idle, resume
        halt = 1; step(); halt = 0;
        checkPc("halt", 8'h07, 2'd1);
        check("halt_flag", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            jmp = (i == 1); ret = (i == 2); jump_target = 8'hAA;
            step();
            checkPc($sformatf("hold%0d", i), 8'h07, 2'd1);
            check($sformatf("hold%0d_flag", i), {31'd0, halted}, 32'd1);
        end
        jmp = 0; ret = 0;
        resume = 1; step(); resume = 0;
        check("resume_flag", {31'd0, halted}, 32'd0);
        checkPc("resume_edge", 8'h07, 2'd1);
        step();
        checkPc("after_resume", 8'h08, 2'd1);
        stall = 1; step();
        checkPc("stall1", 8'h08, 2'd1);
        step(); stall = 0;
        checkPc("stall2", 8'h08, 2'd1);
        step();
        checkPc("unstall", 8'h09, 2'd1);

        // jr leaves the stack alone; sequential wrap 0xFF -> 0x00
        jr = 1; jr_target = 8'hFE; step(); jr = 0;
        checkPc("jr", 8'hFE, 2'd1);
        step();
        checkPc("at_ff", 8'hFF, 2'd1);
        check("link_ff", {24'd0, link_addr}, 32'h00);
        step();
        checkPc("wrap", 8'h00, 2'd1);

        // Reset while halted with two stacked entries
        jal = 1; jump_target = 8'h30; step(); jal = 0;
        checkPc("push2", 8'h30, 2'd2);
        halt = 1; step(); halt = 0;
        check("halt2_flag", {31'd0, halted}, 32'd1);
        reset = 1; halt = 1; step(); reset = 0; halt = 0;
        checkPc("rst_halted", 8'h00, 2'd0);
        check("rst2_halted", {31'd0, halted}, 32'd0);
        check("rst2_ovf", {31'd0, ras_overflow}, 32'd0);
        check("rst2_unf", {31'd0, ras_underflow}, 32'd0);
        step();
        checkPc("rst2_run", 8'h01, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
